// File: rtl/fetch_queue.sv
// fetch_queue: in-order imem fetch buffer between program_counter and decode.
// Define FETCH_PERF_EN to add the FetchCount/BubbleCount performance counters.
module fetch_queue #(
    parameter int          DEPTH   = 2,
    parameter int          MAX_OUT = 2,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        FetchStallF,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pend_q  [MAX_OUT];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0] prd_q, prd_d, pwr_q, pwr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] out_q, out_d, drop_q, drop_d;
    logic          accept, rv, push, pop;

    always_comb begin
        // Reserving a slot per outstanding request guarantees every response has room.
        ImemReq     = !rst && !FlushD && (32'(out_q) < MAX_OUT) && (32'(count_q) + 32'(out_q) < DEPTH);
        ImemAddr    = PCF;
        accept      = ImemReq && ImemGnt;
        FetchStallF = !accept && !FlushD;
        rv          = ImemRValid && (out_q != '0);
        push        = rv && (drop_q == '0) && !FlushD;
        ValidD      = (count_q != '0);
        pop         = ValidD && !StallD && !FlushD;
        InstrD      = ValidD ? instr_q[rd_q] : NOP;
        PCD         = ValidD ? pc_q[rd_q] : 32'd0;
        PCPlus4D    = PCD + 32'd4;
        rd_d        = FlushD ? '0 : rd_q + AW'(pop);
        wr_d        = FlushD ? '0 : wr_q + AW'(push);
        count_d     = FlushD ? '0 : count_q + CW'(push) - CW'(pop);
        prd_d       = rv ? ((prd_q == PW'(MAX_OUT - 1)) ? '0 : prd_q + PW'(1)) : prd_q;
        pwr_d       = accept ? ((pwr_q == PW'(MAX_OUT - 1)) ? '0 : pwr_q + PW'(1)) : pwr_q;
        out_d       = out_q + OW'(accept) - OW'(rv);
        // Pending PCs survive a flush so the dropped responses still pop them in order.
        drop_d      = FlushD ? out_q - OW'(rv) : drop_q - OW'(rv && (drop_q != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            prd_q   <= '0;
            pwr_q   <= '0;
            count_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            prd_q   <= prd_d;
            pwr_q   <= pwr_d;
            count_q <= count_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_q] <= ImemRData;
            pc_q[wr_q]    <= pend_q[prd_q];
        end
        if (accept)
            pend_q[pwr_q] <= PCF;
    end

    always_ff @(posedge clk)
        if (!rst)
            assert (!(ImemRValid && (out_q == '0)));

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (push)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (!ValidD && !StallD)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random fetch/stall/flush/grant traffic against a queue-based model of the fetch stage.
module tb_fetch_queue;
    localparam int          DEPTH   = 2;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PCF = '0;
    logic        FetchStallF, ImemReq, ValidD;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
    logic        ImemGnt = 1'b0, ImemRValid = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic [31:0] ImemRData = '0;

    ent_t        dq[$];
    logic [31:0] pend[$];
    logic [31:0] memq[$];
    int          drop = 0;
    logic [31:0] pc = '0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .FetchStallF(FetchStallF),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .StallD(StallD), .FlushD(FlushD), .ValidD(ValidD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
    );

    function automatic logic [31:0] word(logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0155;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        FlushD = 1'b0; StallD = 1'b0; ImemGnt = 1'b1; ImemRValid = 1'b0; ImemRData = '0; PCF = '0;
        dq.delete(); pend.delete(); memq.delete(); drop = 0; pc = '0;
        #3;
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_stallf", 32'(FetchStallF), 32'd1);
        chk("rst_valid", 32'(ValidD), 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 32'd0);
        chk("rst_pcp4", PCPlus4D, 32'd4);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cycle(bit stall, bit flush, bit gnt, bit rv_en, logic [31:0] tgt);
        bit er, acc_m, acc_d, rv, do_pop;
        logic [31:0] p;
        rv = rv_en && (memq.size() > 0);
        StallD = stall; FlushD = flush; ImemGnt = gnt; PCF = pc;
        ImemRValid = rv;
        ImemRData = rv ? word(memq[0]) : $urandom;
        #3;
        er = !flush && (pend.size() < MAX_OUT) && (dq.size() + pend.size() < DEPTH);
        acc_m = er && gnt;
        acc_d = ImemReq && ImemGnt;
        chk("req", 32'(ImemReq), 32'(er));
        chk("addr", ImemAddr, pc);
        chk("stallf", 32'(FetchStallF), 32'(!acc_m && !flush));
        chk("valid", 32'(ValidD), 32'(dq.size() != 0));
        if (dq.size() != 0) begin
            chk("instr", InstrD, dq[0].instr);
            chk("pcd", PCD, dq[0].pc);
            chk("pcp4", PCPlus4D, dq[0].pc + 32'd4);
        end else
            chk("nop", InstrD, NOP);
        do_pop = (dq.size() != 0) && !stall && !flush;
        @(posedge clk);
        if (do_pop)
            void'(dq.pop_front());
        if (rv) begin
            void'(memq.pop_front());
            if (pend.size() == 0)
                chk("pend_underflow", 32'd1, 32'd0);
            else begin
                p = pend.pop_front();
                if (!flush) begin
                    if (drop > 0) drop--;
                    else dq.push_back('{word(p), p});
                end
            end
        end
        if (flush) begin
            dq.delete();
            drop = pend.size();
        end
        if (acc_m) pend.push_back(pc);
        if (acc_d) memq.push_back(PCF);
        pc = flush ? tgt : (acc_m ? pc + 32'd4 : pc);
        #1;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b0, 1'b1, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
        for (int i = 0; i < 3000; i++) begin
            bit st, fl, gn, rv;
            logic [31:0] tgt;
            if (i == 1500) do_reset();
            st = ($urandom_range(0, 9) < 3) || (i % 400 < 8);
            fl = ($urandom_range(0, 99) < 6) && (i % 400 >= 8);
            gn = $urandom_range(0, 9) < 7;
            rv = $urandom_range(0, 9) < 6;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            cycle(st, fl, gn, rv, tgt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
